gc_page_mover: RTL and testbench
================================

// Module: gc_page_mover
// PURPOSE
//  Downstream stage of garbage_collection. On move_flag, relocates every valid page of the victim
//  block (erase_blk) into the active block (active_blk, page by page), erases the victim, then hands
//  it back as clean via fifo_recover_en/recover_blk and pulses move_done_flag. Sits between GC and
//  the NVM command controller; also reports page invalidations/remaps to the FTL map.
// PARAMETERS
//  BLOCK_W   10  block index width (1024 blocks)
//  PAGE_W    6   page index width (64 pages/block)
// PORTS
//  CLK             in   1               system clock
//  nRST            in   1               async active-low reset
//  move_flag       in   1               start pulse from GC
//  erase_blk       in   BLOCK_W         victim block, sampled with move_flag
//  active_blk      in   BLOCK_W         current clean write block (GC fifo head)
//  active_request  out  1               1-cycle pulse: pop next clean block from GC fifo
//  valid_rd_en     out  1               valid-bitmap lookup strobe
//  valid_addr      out  BLOCK_W+PAGE_W  {blk,page} looked up
//  valid_bit       in   1               bitmap result, exactly 1 cycle after valid_rd_en
//  nvm_req         out  1               NVM command request (level)
//  nvm_op          out  2               00 read, 01 program, 10 erase
//  nvm_addr        out  BLOCK_W+PAGE_W  {blk,page}; page=0 for erase
//  nvm_ack         in   1               NVM command complete
//  map_upd         out  1               1-cycle pulse: remap map_old_addr -> map_new_addr
//  map_old_addr    out  BLOCK_W+PAGE_W  source page
//  map_new_addr    out  BLOCK_W+PAGE_W  destination page
//  move_done_flag  out  1               1-cycle pulse: victim moved and erased
//  fifo_recover_en out  1               1-cycle pulse, same cycle as move_done_flag
//  recover_blk     out  BLOCK_W         erased block returned to GC fifo
//  busy            out  1               high in any state except IDLE
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, victim reg 0, src page 0, write pointer wr_page 0.
//  FSM: IDLE -move_flag-> CHECK (latch erase_blk, src_page=0)
//   CHECK: valid_rd_en=1, valid_addr={victim,src_page} -> WAITV
//   WAITV: valid_bit=1 -> READ; else -> NEXT
//   READ: nvm_req,op=00,addr={victim,src_page} until nvm_ack -> PROG
//   PROG: nvm_req,op=01,addr={active_blk,wr_page} until nvm_ack -> UPDATE
//   UPDATE: map_upd pulse (old={victim,src_page}, new={active_blk,wr_page}); wr_page+1 -> NEXT
//   NEXT: src_page==2^PAGE_W-1 -> ERASE; else src_page+1 -> CHECK
//   ERASE: nvm_req,op=10,addr={victim,0} until nvm_ack -> DONE
//   DONE: move_done_flag=fifo_recover_en=1, recover_blk=victim -> IDLE
//  Handshake: nvm_req/op/addr stable while waiting; ack sampled on CLK; req low the cycle after ack.
//   nvm_ack outside a request state is ignored.
//  wr_page wrap: in UPDATE when wr_page==2^PAGE_W-1, wr_page->0 and active_request pulses that same
//   cycle; next PROG uses the new active_blk (GC updates fifo head within 1 cycle).
//  Victim==active_blk at start: active_request pulsed in first CHECK cycle, wr_page->0.
//  move_flag while busy: ignored (no queueing). Zero valid pages: 64 CHECK/WAITV/NEXT passes, then ERASE.
//  Latency, no valid pages, ack 1 cycle after req: 3*64 + ERASE(2) + DONE(1) cycles.
//  Async reset mid-operation: abort immediately, nvm_req drops, no done/recover pulse.
// CONFIGURATION
//  GC_MOVER_STATS_EN defined: extra outputs moved_pages [PAGE_W:0] (pages moved in last job,
//   cleared at job start) and erase_count [15:0] (saturating at 16'hFFFF, +1 per DONE).
//  Undefined: ports and counters absent; core behaviour identical.
// TESTING
//  Victim 5, valid pages {0,63}, ack after 2 cycles -> two READ/PROG pairs, map_upd 5:0->A:0, 5:63->A:1,
//   erase {5,0}, DONE pulse with recover_blk=5.
//  Victim 7, no valid pages -> no READ/PROG, erase after 192 cycles, move_done_flag one cycle.
//  wr_page=62, 3 valid pages -> programs to wr_page 62,63, active_request pulse, third to {new_blk,0}.
//  move_flag re-pulsed mid-job with erase_blk=9 -> ignored; recover_blk stays original victim.
//  nRST low during PROG -> nvm_req=0, busy=0 next edge; no map_upd/done; fresh job starts clean.
//  GC_MOVER_STATS_EN: two jobs (2 and 0 valid pages) -> moved_pages=0, erase_count=2.

Source files
------------

// File: rtl/gc_page_mover.sv
// gc_page_mover: copies every valid page of a GC victim block into the active write block,
// erases the victim and returns it to the clean fifo. Optional macro GC_MOVER_STATS_EN adds job statistics.
module gc_page_mover #(
    parameter int BLOCK_W = 10,
    parameter int PAGE_W  = 6
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic                       move_flag,
    input  logic [BLOCK_W-1:0]         erase_blk,
    input  logic [BLOCK_W-1:0]         active_blk,
    output logic                       active_request,
    output logic                       valid_rd_en,
    output logic [BLOCK_W+PAGE_W-1:0]  valid_addr,
    input  logic                       valid_bit,
    output logic                       nvm_req,
    output logic [1:0]                 nvm_op,
    output logic [BLOCK_W+PAGE_W-1:0]  nvm_addr,
    input  logic                       nvm_ack,
    output logic                       map_upd,
    output logic [BLOCK_W+PAGE_W-1:0]  map_old_addr,
    output logic [BLOCK_W+PAGE_W-1:0]  map_new_addr,
    output logic                       move_done_flag,
    output logic                       fifo_recover_en,
    output logic [BLOCK_W-1:0]         recover_blk,
`ifdef GC_MOVER_STATS_EN
    output logic                       busy,
    output logic [PAGE_W:0]            moved_pages,
    output logic [15:0]                erase_count
`else
    output logic                       busy
`endif
);

    localparam logic [PAGE_W-1:0] LAST_PAGE = '1;
    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_PROG  = 2'b01;
    localparam logic [1:0] OP_ERASE = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE, S_CHECK, S_WAITV, S_READ, S_PROG, S_UPDATE, S_NEXT, S_ERASE, S_DONE
    } state_t;

    state_t              state_reg, state_next;
    logic [BLOCK_W-1:0]  victim_reg, victim_next;
    logic [PAGE_W-1:0]   src_page_reg, src_page_next;
    logic [PAGE_W-1:0]   wr_page_reg, wr_page_next;
    logic                first_check_reg, first_check_next;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg       <= S_IDLE;
            victim_reg      <= '0;
            src_page_reg    <= '0;
            wr_page_reg     <= '0;
            first_check_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            victim_reg      <= victim_next;
            src_page_reg    <= src_page_next;
            wr_page_reg     <= wr_page_next;
            first_check_reg <= first_check_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        victim_next      = victim_reg;
        src_page_next    = src_page_reg;
        wr_page_next     = wr_page_reg;
        first_check_next = first_check_reg;
        active_request   = 1'b0;
        valid_rd_en      = 1'b0;
        valid_addr       = '0;
        nvm_req          = 1'b0;
        nvm_op           = OP_READ;
        nvm_addr         = '0;
        map_upd          = 1'b0;
        map_old_addr     = '0;
        map_new_addr     = '0;
        move_done_flag   = 1'b0;
        fifo_recover_en  = 1'b0;
        recover_blk      = '0;

        unique case (state_reg)
            S_IDLE: begin
                if (move_flag) begin
                    victim_next      = erase_blk;
                    src_page_next    = '0;
                    first_check_next = 1'b1;
                    state_next       = S_CHECK;
                end
            end
            S_CHECK: begin
                valid_rd_en      = 1'b1;
                valid_addr       = {victim_reg, src_page_reg};
                first_check_next = 1'b0;
                // Never program into the block being erased: fetch a fresh one up front
                if (first_check_reg && (victim_reg == active_blk)) begin
                    active_request = 1'b1;
                    wr_page_next   = '0;
                end
                state_next = S_WAITV;
            end
            S_WAITV: begin
                state_next = valid_bit ? S_READ : S_NEXT;
            end
            S_READ: begin
                nvm_req  = 1'b1;
                nvm_op   = OP_READ;
                nvm_addr = {victim_reg, src_page_reg};
                if (nvm_ack)
                    state_next = S_PROG;
            end
            S_PROG: begin
                nvm_req  = 1'b1;
                nvm_op   = OP_PROG;
                nvm_addr = {active_blk, wr_page_reg};
                if (nvm_ack)
                    state_next = S_UPDATE;
            end
            S_UPDATE: begin
                map_upd      = 1'b1;
                map_old_addr = {victim_reg, src_page_reg};
                map_new_addr = {active_blk, wr_page_reg};
                if (wr_page_reg == LAST_PAGE) begin
                    wr_page_next   = '0;
                    active_request = 1'b1;
                end else begin
                    wr_page_next = wr_page_reg + 1'b1;
                end
                state_next = S_NEXT;
            end
            S_NEXT: begin
                if (src_page_reg == LAST_PAGE) begin
                    state_next = S_ERASE;
                end else begin
                    src_page_next = src_page_reg + 1'b1;
                    state_next    = S_CHECK;
                end
            end
            S_ERASE: begin
                nvm_req  = 1'b1;
                nvm_op   = OP_ERASE;
                nvm_addr = {victim_reg, {PAGE_W{1'b0}}};
                if (nvm_ack)
                    state_next = S_DONE;
            end
            S_DONE: begin
                move_done_flag  = 1'b1;
                fifo_recover_en = 1'b1;
                recover_blk     = victim_reg;
                state_next      = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign busy = (state_reg != S_IDLE);

`ifdef GC_MOVER_STATS_EN
    logic [PAGE_W:0] moved_pages_reg;
    logic [15:0]     erase_count_reg;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            moved_pages_reg <= '0;
            erase_count_reg <= '0;
        end else begin
            if (state_reg == S_IDLE && move_flag)
                moved_pages_reg <= '0;
            else if (state_reg == S_UPDATE)
                moved_pages_reg <= moved_pages_reg + {{PAGE_W{1'b0}}, 1'b1};
            if (state_reg == S_DONE && erase_count_reg != 16'hFFFF)
                erase_count_reg <= erase_count_reg + 16'd1;
        end
    end

    assign moved_pages = moved_pages_reg;
    assign erase_count = erase_count_reg;
`endif

endmodule

// File: tb/tb_gc_page_mover.sv
// Directed bench for gc_page_mover: models the valid bitmap, NVM acks and the GC fifo head,
// and checks commands, remaps and done pulses against hand-computed values.
module tb_gc_page_mover;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        move_flag = 1'b0;
    logic [9:0]  erase_blk = '0;
    logic [9:0]  active_blk = 10'd10;
    logic        active_request;
    logic        valid_rd_en;
    logic [15:0] valid_addr;
    logic        valid_bit;
    logic        nvm_req;
    logic [1:0]  nvm_op;
    logic [15:0] nvm_addr;
    logic        nvm_ack;
    logic        map_upd;
    logic [15:0] map_old_addr;
    logic [15:0] map_new_addr;
    logic        move_done_flag;
    logic        fifo_recover_en;
    logic [9:0]  recover_blk;
    logic        busy;
`ifdef GC_MOVER_STATS_EN
    logic [6:0]  moved_pages;
    logic [15:0] erase_count;
`endif

    gc_page_mover #(.BLOCK_W(10), .PAGE_W(6)) dut (
        .CLK(CLK), .nRST(nRST), .move_flag(move_flag), .erase_blk(erase_blk),
        .active_blk(active_blk), .active_request(active_request),
        .valid_rd_en(valid_rd_en), .valid_addr(valid_addr), .valid_bit(valid_bit),
        .nvm_req(nvm_req), .nvm_op(nvm_op), .nvm_addr(nvm_addr), .nvm_ack(nvm_ack),
        .map_upd(map_upd), .map_old_addr(map_old_addr), .map_new_addr(map_new_addr),
        .move_done_flag(move_done_flag), .fifo_recover_en(fifo_recover_en),
        .recover_blk(recover_blk),
`ifdef GC_MOVER_STATS_EN
        .busy(busy), .moved_pages(moved_pages), .erase_count(erase_count)
`else
        .busy(busy)
`endif
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Environment models
    logic valid_mem [0:65535];
    int   ack_dly = 1;
    int   ack_cnt;

    always @(posedge CLK) valid_bit <= valid_rd_en ? valid_mem[valid_addr] : 1'b0;

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ack_cnt <= 0;
            nvm_ack <= 1'b0;
        end else begin
            nvm_ack <= 1'b0;
            if (nvm_req && !nvm_ack) begin
                if (ack_cnt >= ack_dly - 1) begin
                    nvm_ack <= 1'b1;
                    ack_cnt <= 0;
                end else begin
                    ack_cnt <= ack_cnt + 1;
                end
            end
        end
    end

    always @(posedge CLK) if (active_request) active_blk <= active_blk + 10'd1;

    // Monitor, sampled on the falling edge
    logic [31:0] cmdq[$];
    logic [31:0] mapq[$];
    int areq_cnt = 0, done_cnt = 0, rec_en_cnt = 0;
    int busy_cyc = 0, erase_at = 0, last_erase_at = 0, done_at = 0;
    logic [9:0] last_recover = '0;

    always @(negedge CLK) begin
        if (!busy) begin
            busy_cyc = 0;
            erase_at = 0;
        end else begin
            busy_cyc++;
            if (nvm_req && nvm_op == 2'b10 && erase_at == 0) erase_at = busy_cyc;
        end
        if (nvm_req && nvm_ack) cmdq.push_back({14'd0, nvm_op, nvm_addr});
        if (map_upd) mapq.push_back({map_old_addr, map_new_addr});
        if (active_request) areq_cnt++;
        if (fifo_recover_en) rec_en_cnt++;
        if (move_done_flag) begin
            done_cnt++;
            done_at = busy_cyc;
            last_erase_at = erase_at;
            last_recover = recover_blk;
        end
    end

    int cmd_base, cmd_rd, map_base, map_rd, areq_base, done_base;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] pa(input int b, input int p);
        return 16'(b * 64 + p);
    endfunction

    task automatic exp_cmd(input string tag, input logic [1:0] op, input int b, input int p);
        logic [31:0] got;
        got = (cmd_rd < cmdq.size()) ? cmdq[cmd_rd] : 32'hFFFF_FFFF;
        cmd_rd++;
        check_val(tag, got, {14'd0, op, pa(b, p)});
    endtask

    task automatic exp_map(input string tag, input int ob, input int op_, input int nb, input int np);
        logic [31:0] got;
        got = (map_rd < mapq.size()) ? mapq[map_rd] : 32'hFFFF_FFFF;
        map_rd++;
        check_val(tag, got, {pa(ob, op_), pa(nb, np)});
    endtask

    task automatic prep_job(input int dly);
        ack_dly   = dly;
        cmd_base  = cmdq.size();
        cmd_rd    = cmd_base;
        map_base  = mapq.size();
        map_rd    = map_base;
        areq_base = areq_cnt;
        done_base = done_cnt;
    endtask

    task automatic pulse_move(input int blk);
        @(negedge CLK);
        erase_blk = 10'(blk);
        move_flag = 1'b1;
        @(negedge CLK);
        move_flag = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (done_cnt == done_base && n < budget) begin
            @(negedge CLK);
            #1;
            n++;
        end
        repeat (2) begin
            @(negedge CLK);
            #1;
        end
        check_val({tag, "_done_pulses"}, 32'(done_cnt - done_base), 32'd1);
        check_val({tag, "_idle"}, {31'd0, busy}, 32'd0);
        $display("job %s: recover_blk=%0d cmds=%0d remaps=%0d", tag, last_recover,
                 cmdq.size() - cmd_base, mapq.size() - map_base);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 65536; i++) valid_mem[i] = 1'b0;

        // Reset state
        repeat (3) @(negedge CLK);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_nvm_req", {31'd0, nvm_req}, 32'd0);
        check_val("rst_nvm_addr", {16'd0, nvm_addr}, 32'd0);
        check_val("rst_strobes", {27'd0, active_request, valid_rd_en, map_upd,
                  move_done_flag, fifo_recover_en}, 32'd0);
        check_val("rst_recover_blk", {22'd0, recover_blk}, 32'd0);
        nRST = 1'b1;

        // Job 1: victim 5, valid pages 0 and 63, ack after 2 cycles
        valid_mem[pa(5, 0)]  = 1'b1;
        valid_mem[pa(5, 63)] = 1'b1;
        prep_job(2);
        pulse_move(5);
        wait_done("j1", 2000);
        exp_cmd("j1_rd0", 2'b00, 5, 0);
        exp_cmd("j1_pg0", 2'b01, 10, 0);
        exp_cmd("j1_rd63", 2'b00, 5, 63);
        exp_cmd("j1_pg1", 2'b01, 10, 1);
        exp_cmd("j1_erase", 2'b10, 5, 0);
        check_val("j1_cmd_count", 32'(cmdq.size() - cmd_base), 32'd5);
        exp_map("j1_map0", 5, 0, 10, 0);
        exp_map("j1_map1", 5, 63, 10, 1);
        check_val("j1_map_count", 32'(mapq.size() - map_base), 32'd2);
        check_val("j1_recover", {22'd0, last_recover}, 32'd5);
`ifdef GC_MOVER_STATS_EN
        check_val("j1_moved_pages", {25'd0, moved_pages}, 32'd2);
`endif

        // Job 2: victim 7 with no valid pages; move_flag for 9 mid-job must be ignored
        prep_job(1);
        pulse_move(7);
        repeat (50) @(negedge CLK);
        pulse_move(9);
        wait_done("j2", 400);
        exp_cmd("j2_erase", 2'b10, 7, 0);
        check_val("j2_cmd_count", 32'(cmdq.size() - cmd_base), 32'd1);
        check_val("j2_map_count", 32'(mapq.size() - map_base), 32'd0);
        check_val("j2_erase_cycle", 32'(last_erase_at), 32'd193);
        check_val("j2_done_cycle", 32'(done_at), 32'd195);
        check_val("j2_recover", {22'd0, last_recover}, 32'd7);
`ifdef GC_MOVER_STATS_EN
        check_val("stats_moved_pages", {25'd0, moved_pages}, 32'd0);
        check_val("stats_erase_count", {16'd0, erase_count}, 32'd2);
`endif

        // Job 3: victim 20 with 60 valid pages, advancing the write pointer from 2 to 62
        for (int p = 0; p < 60; p++) valid_mem[pa(20, p)] = 1'b1;
        prep_job(1);
        pulse_move(20);
        wait_done("j3", 5000);
        check_val("j3_map_count", 32'(mapq.size() - map_base), 32'd60);
        map_rd = map_base + 59;
        exp_map("j3_last_map", 20, 59, 10, 61);
        check_val("j3_areq", 32'(areq_cnt - areq_base), 32'd0);

        // Job 4: three valid pages straddling the end of the active block
        valid_mem[pa(21, 1)] = 1'b1;
        valid_mem[pa(21, 2)] = 1'b1;
        valid_mem[pa(21, 3)] = 1'b1;
        prep_job(1);
        pulse_move(21);
        wait_done("j4", 2000);
        exp_map("j4_map62", 21, 1, 10, 62);
        exp_map("j4_map63", 21, 2, 10, 63);
        exp_map("j4_map_wrap", 21, 3, 11, 0);
        check_val("j4_areq", 32'(areq_cnt - areq_base), 32'd1);
        cmd_rd = cmd_base + 5;
        exp_cmd("j4_prog_wrap", 2'b01, 11, 0);
        check_val("j4_recover", {22'd0, last_recover}, 32'd21);

        // Job 5: reset asserted while programming
        valid_mem[pa(30, 5)] = 1'b1;
        prep_job(3);
        pulse_move(30);
        n = 0;
        while (!(nvm_req && nvm_op == 2'b01) && n < 1000) begin
            @(negedge CLK);
            n++;
        end
        check_val("j5_reached_prog", {31'd0, nvm_req && nvm_op == 2'b01}, 32'd1);
        nRST = 1'b0;
        #1;
        check_val("j5_rst_req", {31'd0, nvm_req}, 32'd0);
        check_val("j5_rst_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge CLK);
        #1;
        check_val("j5_no_map", 32'(mapq.size() - map_base), 32'd0);
        check_val("j5_no_done", 32'(done_cnt - done_base), 32'd0);
        check_val("j5_no_recover", 32'(rec_en_cnt - done_cnt), 32'd0);
        nRST = 1'b1;

        // Job 6: victim equals the active block after reset
        valid_mem[pa(11, 0)] = 1'b1;
        prep_job(1);
        pulse_move(11);
        wait_done("j6", 1000);
        check_val("j6_areq", 32'(areq_cnt - areq_base), 32'd1);
        exp_cmd("j6_rd", 2'b00, 11, 0);
        exp_cmd("j6_pg", 2'b01, 12, 0);
        exp_cmd("j6_erase", 2'b10, 11, 0);
        exp_map("j6_map", 11, 0, 12, 0);
        check_val("j6_recover", {22'd0, last_recover}, 32'd11);
        check_val("recover_en_matches_done", 32'(rec_en_cnt), 32'(done_cnt));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
